universal_shift_register: RTL
=============================

# universal_shift_register

- Parametrised universal shift register with `WIDTH` bits.
- Supports four single-step modes: hold, shift right, shift left and parallel load.
- Adds a multi-step burst engine: it shifts a programmed number of positions autonomously, with a `Busy` flag and a one-cycle `Done` pulse.
- Sits in the microbenchmark set as the generalised successor of the fixed 4-bit load/shift register.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits; must be ≥ 2.
- `CW`, 4: burst count width; maximum burst is 2^CW−1 shifts.

Ports:
- `Clock`  in  1  clock; all state updates on the rising edge.
- `Resetn`  in  1  synchronous, active-low reset.
- `R`  in  WIDTH  parallel load data.
- `Mode`  in  2  single-step op: 00 hold, 01 shift right, 10 shift left, 11 load `R`.
- `w`  in  1  serial input bit.
- `Start`  in  1  burst request.
- `Dir`  in  1  burst direction: 0 right, 1 left.
- `Count`  in  CW  number of burst shifts.
- `Rotate`  in  1  rotate request; only effective with `USR_ROTATE_EN`.
- `Q`  out  WIDTH  register contents.
- `Sout_r`  out  1  `Q[0]`, combinational.
- `Sout_l`  out  1  `Q[WIDTH-1]`, combinational.
- `Busy`  out  1  burst in progress (registered).
- `Done`  out  1  one-cycle burst completion pulse (registered).

## Operation
- **Reset:** `Resetn`=0 at an edge forces `Q`=0, `Busy`=0, `Done`=0, state IDLE, remaining count 0. Reset has priority over everything.
- **Shift right:** `Q` ← {in, `Q[WIDTH-1:1]`}. The new bit enters at the MSB.
- **Shift left:** `Q` ← {`Q[WIDTH-2:0]`, in}. The new bit enters at the LSB.
- **Shift-in bit:**
  - Normally `w`.
  - With rotate active, it is the bit being shifted out: `Q[0]` for right, `Q[WIDTH-1]` for left.
- **FSM states:** IDLE, SHIFT.
- **IDLE:**
  - `Start`=1 with `Count`≠0: capture `Count` into the remaining counter and `Dir` into a direction register, then go to SHIFT. `Q` holds on this edge and `Mode` is ignored.
  - `Start`=1 with `Count`=0: ignored; `Mode` applies as normal.
  - Otherwise `Mode` executes one step per edge.
- **SHIFT:**
  - Each edge shifts once in the captured direction, using the current `w` and current `Rotate`, and decrements the remaining counter.
  - On the edge where remaining goes 1→0, return to IDLE.
  - `Mode`, `Start`, `Count` and `Dir` are ignored throughout SHIFT.
- **Outputs:**
  - `Busy` = 1 exactly while in SHIFT.
  - `Done` = 1 for the single cycle after the final shift edge; it is 0 otherwise.
- **Done-cycle behaviour:** during the `Done` cycle the block is in IDLE and accepts `Start` or `Mode`. Back-to-back bursts are therefore possible.
- **Reset mid-burst:** aborts the burst. No `Done` is produced and `Q`=0.

## Timing
- Single-step ops: `Q` updates on the edge where `Mode` is sampled (latency 1).
- Burst accepted at edge k:
  - `Q` shifts at edges k+1 … k+`Count`.
  - `Busy` is high from after edge k until edge k+`Count`.
  - `Done` is high for the cycle following edge k+`Count`.
- A burst occupies `Count`+1 edges, including the acceptance edge.
- `Sout_r` and `Sout_l` follow `Q` with no added delay.

## Configuration
- Macro: `USR_ROTATE_EN`.
- **Defined:** `Rotate`=1 substitutes the shifted-out bit for `w`.
  - Applies to single-step shift modes and to every burst shift.
  - `Rotate` is sampled on each edge.
- **Undefined:** the `Rotate` port exists but is ignored; `w` is always the shift-in bit. Port list is identical in both builds.

## Test plan
Test parameters are `WIDTH`=8, `CW`=4.
- **Reset:** load 0xFF, then `Resetn`=0 for one edge → `Q`=0x00, `Busy`=0, `Done`=0.
- **Single-step ops:** `Mode`=11, `R`=0xA5 → `Q`=0xA5; `Mode`=01, `w`=1 → 0xD2; `Mode`=10, `w`=0 → 0xA4; `Mode`=00 → stays 0xA4.
- **Right burst:** `Q`=0x81, `Start`=1, `Dir`=0, `Count`=3, `w`=0 → `Q` = 0x40, 0x20, 0x10 on successive edges, `Busy` high for 3 cycles, then `Done` pulses once. `Mode`=11 driven during `Busy` has no effect.
- **Rotate (macro defined):**
  - From `Q`=0x81: `Mode`=01, `Rotate`=1 → 0xC0.
  - From `Q`=0x81: `Mode`=10, `Rotate`=1 → 0x03.
  - Left burst, `Count`=8, `Rotate`=1 from 0x81 → returns to 0x81.
  - Macro undefined, `w`=0, `Mode`=01 from 0x81 → 0x40.
- **Reset mid-burst:** `Count`=15, `Resetn`=0 after 2 shifts → `Q`=0x00, `Busy`=0, no `Done` pulse.
- **Start corner cases:**
  - `Start` with `Count`=0 → no `Busy`/`Done`, and `Mode` executes.
  - `Start` during `Busy` → ignored.
  - `Start` during the `Done` cycle → new burst accepted, with `Busy` high on the next cycle.

Source files
------------

// File: rtl/universal_shift_register.sv
// universal_shift_register
//   Parametrised universal shift register with single-step hold / shift right /
//   shift left / parallel load, plus an autonomous multi-step burst engine.
//
//   Optional feature macro: USR_ROTATE_EN
//     defined   : Rotate=1 feeds the shifted-out bit back in (rotate) for both
//                 single-step shifts and every burst shift.
//     undefined : Rotate is ignored; w is always the shift-in bit.
//
//   Ports:
//     Clock   in   1      rising-edge clock
//     Resetn  in   1      synchronous active-low reset
//     R       in   WIDTH  parallel load data
//     Mode    in   2      00 hold, 01 shift right, 10 shift left, 11 load R
//     w       in   1      serial input bit
//     Start   in   1      burst request
//     Dir     in   1      burst direction: 0 right, 1 left
//     Count   in   CW     number of burst shifts (0 = no burst)
//     Rotate  in   1      rotate request (USR_ROTATE_EN builds only)
//     Q       out  WIDTH  register contents
//     Sout_r  out  1      Q[0]
//     Sout_l  out  1      Q[WIDTH-1]
//     Busy    out  1      burst in progress
//     Done    out  1      one-cycle burst completion pulse
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] R,
  input  logic [1:0]       Mode,
  input  logic             w,
  input  logic             Start,
  input  logic             Dir,
  input  logic [CW-1:0]    Count,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Q,
  output logic             Sout_r,
  output logic             Sout_l,
  output logic             Busy,
  output logic             Done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    remaining;
  logic             dir_q;
  logic             rot_active;
  logic             in_r;
  logic             in_l;
  logic [WIDTH-1:0] q_shr;
  logic [WIDTH-1:0] q_shl;

`ifdef USR_ROTATE_EN
  assign rot_active = Rotate;
`else
  logic unused_rotate;
  assign unused_rotate = Rotate;
  assign rot_active    = 1'b0;
`endif

  // Shift-in bit: serial input, or the bit leaving the register when rotating.
  always_comb begin
    in_r  = rot_active ? Q[0]       : w;
    in_l  = rot_active ? Q[WIDTH-1] : w;
    q_shr = {in_r, Q[WIDTH-1:1]};
    q_shl = {Q[WIDTH-2:0], in_l};
  end

  assign Sout_r = Q[0];
  assign Sout_l = Q[WIDTH-1];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Q         <= '0;
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start && (Count != '0)) begin
          // Acceptance edge: Q holds, Mode is ignored.
          remaining <= Count;
          dir_q     <= Dir;
          state     <= SHIFT;
          Busy      <= 1'b1;
        end else begin
          case (Mode)
            2'b00:   Q <= Q;
            2'b01:   Q <= q_shr;
            2'b10:   Q <= q_shl;
            default: Q <= R;
          endcase
        end
      end else begin
        Q         <= dir_q ? q_shl : q_shr;
        remaining <= remaining - 1'b1;
        if (remaining == CW'(1)) begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end
      end
    end
  end

endmodule
